// File: rtl/dot_scroll_ctrl.sv
// Ten-column dot-matrix window controller: static column writes or timed
// right-to-left scrolling fed from a small column FIFO.
module dot_scroll_ctrl #(
  parameter int SCROLL_DIV = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic        clear,
  input  logic        col_valid,
  input  logic [13:0] col_data,
  output logic        col_ready,
  output logic [13:0] dot_data0,
  output logic [13:0] dot_data1,
  output logic [13:0] dot_data2,
  output logic [13:0] dot_data3,
  output logic [13:0] dot_data4,
  output logic [13:0] dot_data5,
  output logic [13:0] dot_data6,
  output logic [13:0] dot_data7,
  output logic [13:0] dot_data8,
  output logic [13:0] dot_data9,
  output logic        busy,
  output logic        step
);

  localparam int PW = $clog2(SCROLL_DIV);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCROLL_DIV - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_LAST   = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STATIC, SCROLL} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   presc;
  logic [3:0]      wr_col;
  logic [13:0]     win [10];
  logic [13:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic transfer, push, pop, shift, static_wr, flush, fifo_empty;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    col_ready  = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) next_state = mode ? SCROLL : STATIC;
      end
      STATIC: begin
        col_ready = 1'b1;
        if (!enable)   next_state = IDLE;
        else if (mode) next_state = SCROLL;
      end
      SCROLL: begin
        col_ready = (count != FIFO_FULL);
        step      = (presc == PRESC_LAST);
        if (!enable)    next_state = IDLE;
        else if (!mode) next_state = STATIC;
      end
      default: next_state = IDLE;
    endcase
  end

  assign fifo_empty = (count == '0);
  assign busy       = !fifo_empty;
  assign transfer   = col_valid && col_ready && !clear;
  assign static_wr  = transfer && (state == STATIC);
  assign push       = transfer && (state == SCROLL);
  assign shift      = step && !clear;
  assign pop        = shift && !fifo_empty;
  // Leaving SCROLL for STATIC drops queued columns and restarts writes at the left edge.
  assign flush      = clear || ((state == SCROLL) && (next_state == STATIC));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The prescaler only runs while staying in SCROLL; any exit or clear restarts it at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              presc <= '0;
    else if (clear || state != SCROLL || next_state != SCROLL) presc <= '0;
    else if (presc == PRESC_LAST)                            presc <= '0;
    else                                                     presc <= presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      wr_col <= '0;
    else if (flush)                  wr_col <= '0;
    else if (static_wr)              wr_col <= (wr_col == 4'd9) ? 4'd0 : wr_col + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 10; i++) win[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 10; i++) win[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < 9; i++) win[i] <= win[i+1];
      win[9] <= pop ? mem[rd_ptr] : 14'h0000;
    end else if (static_wr) begin
      win[wr_col] <= col_data;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= col_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dot_data0 = win[0];
  assign dot_data1 = win[1];
  assign dot_data2 = win[2];
  assign dot_data3 = win[3];
  assign dot_data4 = win[4];
  assign dot_data5 = win[5];
  assign dot_data6 = win[6];
  assign dot_data7 = win[7];
  assign dot_data8 = win[8];
  assign dot_data9 = win[9];

endmodule

// File: tb/tb_dot_scroll_ctrl.sv
// Directed bench for dot_scroll_ctrl with SCROLL_DIV=4, FIFO_DEPTH=4:
// a vector table for the cycle-by-cycle flow plus hand sequences for reset.
module tb_dot_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, mode, clear, col_valid;
  logic [13:0] col_data;
  logic        col_ready, busy, step;
  logic [13:0] dot_data0, dot_data1, dot_data2, dot_data3, dot_data4;
  logic [13:0] dot_data5, dot_data6, dot_data7, dot_data8, dot_data9;
  logic [13:0] dd [10];

  int checks   = 0;
  int failures = 0;

  dot_scroll_ctrl #(.SCROLL_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .clear(clear),
    .col_valid(col_valid), .col_data(col_data), .col_ready(col_ready),
    .dot_data0(dot_data0), .dot_data1(dot_data1), .dot_data2(dot_data2),
    .dot_data3(dot_data3), .dot_data4(dot_data4), .dot_data5(dot_data5),
    .dot_data6(dot_data6), .dot_data7(dot_data7), .dot_data8(dot_data8),
    .dot_data9(dot_data9), .busy(busy), .step(step)
  );

  assign dd[0] = dot_data0;
  assign dd[1] = dot_data1;
  assign dd[2] = dot_data2;
  assign dd[3] = dot_data3;
  assign dd[4] = dot_data4;
  assign dd[5] = dot_data5;
  assign dd[6] = dot_data6;
  assign dd[7] = dot_data7;
  assign dd[8] = dot_data8;
  assign dd[9] = dot_data9;

  always #5 clk = ~clk;

  typedef struct {
    logic        en, md, clr, vld;
    logic [13:0] data;
    logic        ready, bsy, stp;
    int          idx_a;
    logic [13:0] val_a;
    int          idx_b;
    logic [13:0] val_b;
  } vec_t;

  vec_t tbl[$];
  int   static_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, md, clr, vld, input logic [13:0] data,
                     input logic ready, bsy, stp,
                     input int idx_a = -1, input logic [13:0] val_a = '0,
                     input int idx_b = -1, input logic [13:0] val_b = '0);
    vec_t v;
    v.en = en; v.md = md; v.clr = clr; v.vld = vld; v.data = data;
    v.ready = ready; v.bsy = bsy; v.stp = stp;
    v.idx_a = idx_a; v.val_a = val_a; v.idx_b = idx_b; v.val_b = val_b;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, md, clr, vld, input logic [13:0] data);
    enable = en; mode = md; clear = clr; col_valid = vld; col_data = data;
  endtask

  task automatic cycle(input logic en, md, clr, vld, input logic [13:0] data);
    drive(en, md, clr, vld, data);
    @(negedge clk);
  endtask

  task automatic check_window_zero(input string tag);
    for (int k = 0; k < 10; k++) check($sformatf("%s.dot%0d", tag, k), dd[k], 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Static fill: enter STATIC, then 11 writes wrap onto column 0.
    add(1,0,0,0,14'h0, 1,0,0);
    for (int i = 1; i <= 11; i++) add(1,0,0,1,14'(i), 1,0,0, (i-1) % 10, 14'(i));
    static_end = tbl.size();
    // Scroll one full column across two steps.
    add(1,1,0,0,14'h0,    1,0,0, 1,14'h0002, 0,14'h000B);
    add(1,1,0,1,14'h3FFF, 1,1,0, 9,14'h000A, 0,14'h000B);
    add(1,1,0,0,14'h0,    1,1,0);
    add(1,1,0,0,14'h0,    1,1,1);
    add(1,1,0,0,14'h0,    1,0,0, 9,14'h3FFF, 8,14'h000A);
    add(1,1,0,0,14'h0,    1,0,0);
    add(1,1,0,0,14'h0,    1,0,0);
    add(1,1,0,0,14'h0,    1,0,1);
    add(1,1,0,0,14'h0,    1,0,0, 8,14'h3FFF, 9,14'h0000);
    // Fill the FIFO (pausing once to land a fourth push), then a step frees a slot.
    add(1,1,0,1,14'h101,  1,1,0);
    add(1,1,0,1,14'h102,  1,1,0);
    add(0,1,0,1,14'h103,  0,1,0, 9,14'h0000, 8,14'h3FFF);
    add(1,1,0,1,14'h104,  1,1,0);
    add(1,1,0,1,14'h104,  0,1,0);
    add(1,1,0,1,14'h105,  0,1,0);
    add(1,1,0,1,14'h105,  0,1,1);
    add(1,1,0,1,14'h105,  1,1,0, 9,14'h0101, 8,14'h0000);
    add(1,1,0,0,14'h0,    1,1,0, 7,14'h3FFF, 9,14'h0101);
    add(1,1,0,0,14'h0,    1,1,0);
    add(1,1,0,0,14'h0,    1,1,1);
    // Clear on a step cycle with a column offered.
    add(1,1,1,1,14'h1AA,  1,0,0, 9,14'h0000, 7,14'h0000);
    // Mode switch with two queued entries, then pause.
    add(1,1,0,1,14'h201,  1,1,0);
    add(1,1,0,1,14'h202,  1,1,0);
    add(1,0,0,0,14'h0,    1,0,0);
    add(1,0,0,1,14'h2AB,  1,0,0, 0,14'h02AB, 1,14'h0000);
    add(0,0,0,0,14'h0,    0,0,0, 0,14'h02AB);
    add(0,0,0,1,14'h3CC,  0,0,0, 0,14'h02AB, 1,14'h0000);
    // Back into SCROLL with two entries pending, stopping on a step cycle.
    add(1,1,0,0,14'h0,    1,0,0);
    add(1,1,0,1,14'h3AA,  1,1,0);
    add(1,1,0,1,14'h3BB,  1,1,0);
    add(1,1,0,0,14'h0,    1,1,1, 0,14'h02AB);

    reset = 1'b0;
    drive(0,0,0,0,14'h0);
    #12;
    check("rst.col_ready", col_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.step", step, 0);
    check_window_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].md, tbl[i].clr, tbl[i].vld, tbl[i].data);
      check($sformatf("v%0d.col_ready", i), col_ready, tbl[i].ready);
      check($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
      check($sformatf("v%0d.step", i), step, tbl[i].stp);
      if (tbl[i].idx_a >= 0)
        check($sformatf("v%0d.dot%0d", i, tbl[i].idx_a), dd[tbl[i].idx_a], tbl[i].val_a);
      if (tbl[i].idx_b >= 0)
        check($sformatf("v%0d.dot%0d", i, tbl[i].idx_b), dd[tbl[i].idx_b], tbl[i].val_b);
      if (i == static_end - 1) begin
        check("fill.dot0", dd[0], 14'h000B);
        for (int k = 1; k < 10; k++) check($sformatf("fill.dot%0d", k), dd[k], 14'(k + 1));
      end
    end

    // Asynchronous reset mid-scroll: outputs clear before any further clock edge.
    reset = 1'b0;
    #1;
    check("midrst.col_ready", col_ready, 0);
    check("midrst.busy", busy, 0);
    check("midrst.step", step, 0);
    check_window_zero("midrst");
    drive(0,0,0,0,14'h0);
    @(negedge clk);
    reset = 1'b1;
    cycle(0,0,0,0,14'h0);
    check("post.idle_ready", col_ready, 0);
    check("post.idle_busy", busy, 0);

    // The discarded FIFO must not reappear: the next step shifts in a blank.
    cycle(1,1,0,0,14'h0);
    check("post.scroll_ready", col_ready, 1);
    for (int k = 0; k < 3; k++) cycle(1,1,0,0,14'h0);
    check("post.step", step, 1);
    cycle(1,1,0,0,14'h0);
    check("post.dot9", dd[9], 14'h0000);
    check("post.busy", busy, 0);
    check("post.step_low", step, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
